// File: rtl/multi_border_collision_pkg.sv
// Shared types and arithmetic helpers for the multi-ball border collision unit.
// BORDER_DAMPING_EN adds the damp() helper used to scale reflected velocities by 7/8.
package border_collision_pkg;

    localparam int DEF_W         = 11;
    localparam int DEF_BALL_SIZE = 32;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        HIT      = 2'd1,
        COOLDOWN = 2'd2
    } coll_state_t;

    // The most negative value has no positive twin, so it maps to the largest positive value.
    function automatic logic signed [DEF_W-1:0] sat_neg(input logic signed [DEF_W-1:0] v);
        logic signed [DEF_W-1:0] r;
        if (v == {1'b1, {(DEF_W-1){1'b0}}})
            r = {1'b0, {(DEF_W-1){1'b1}}};
        else
            r = -v;
        return r;
    endfunction

`ifdef BORDER_DAMPING_EN
    function automatic logic signed [DEF_W-1:0] damp(input logic signed [DEF_W-1:0] n);
        logic signed [DEF_W-1:0] r;
        r = n - (n >>> 3);
        // Small magnitudes would otherwise damp to a standstill against the wall.
        if (n != '0 && r == '0)
            r = n[DEF_W-1] ? '1 : DEF_W'(1);
        return r;
    endfunction
`endif

endpackage

// File: rtl/multi_border_collision_channel.sv
// One ball's collision channel: ARMED/HIT/COOLDOWN FSM, frame cooldown counter,
// wall classification and velocity reflection (damped when BORDER_DAMPING_EN is defined).
module border_collision_channel
    import border_collision_pkg::*;
#(
    parameter int W               = DEF_W,
    parameter int BALL_SIZE       = DEF_BALL_SIZE,
    parameter int TOP_OFFSET      = 40,
    parameter int DOWN_OFFSET     = 440,
    parameter int LEFT_OFFSET     = 40,
    parameter int RIGHT_OFFSET    = 600,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start_of_frame,
    input  logic                i_overlap,
    input  logic signed [W-1:0] i_pos_x,
    input  logic signed [W-1:0] i_pos_y,
    input  logic signed [W-1:0] i_vel_x,
    input  logic signed [W-1:0] i_vel_y,
    output logic signed [W-1:0] o_vel_x,
    output logic signed [W-1:0] o_vel_y,
    output logic                o_collision,
    output logic                o_hit_next,
    output logic [1:0]          o_state
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic signed [W:0] L_EDGE = (W+1)'(LEFT_OFFSET);
    localparam logic signed [W:0] R_EDGE = (W+1)'(RIGHT_OFFSET);
    localparam logic signed [W:0] T_EDGE = (W+1)'(TOP_OFFSET);
    localparam logic signed [W:0] B_EDGE = (W+1)'(DOWN_OFFSET);
    localparam logic signed [W:0] SIZE   = (W+1)'(BALL_SIZE);

    coll_state_t         r_state;
    coll_state_t         w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic signed [W-1:0] r_pos_x, r_pos_y, r_vel_x, r_vel_y;
    logic signed [W-1:0] r_vel_x_out, r_vel_y_out;
    logic                r_collision;

    logic                w_hit_next;
    logic signed [W:0]   w_px, w_py, w_px_far, w_py_far;
    logic                w_hit_l, w_hit_r, w_hit_t, w_hit_b;
    logic                w_flip_x, w_flip_y;
    logic signed [W-1:0] w_refl_x, w_refl_y;
    logic signed [W-1:0] w_vel_x_next, w_vel_y_next;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ARMED;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ARMED:    if (i_overlap) w_state_next = HIT;
            HIT:      w_state_next = COOLDOWN;
            COOLDOWN: if (r_cnt == '0 && !i_overlap) w_state_next = ARMED;
            default:  w_state_next = ARMED;
        endcase
    end

    // Classification works on the detect-cycle snapshot, widened by one bit so pos + size cannot wrap.
    always_comb begin
        w_hit_next = (r_state == HIT);
        w_px       = {r_pos_x[W-1], r_pos_x};
        w_py       = {r_pos_y[W-1], r_pos_y};
        w_px_far   = w_px + SIZE;
        w_py_far   = w_py + SIZE;
        w_hit_l    = (w_px <= L_EDGE);
        w_hit_r    = (w_px_far >= R_EDGE);
        w_hit_t    = (w_py <= T_EDGE);
        w_hit_b    = (w_py_far >= B_EDGE);
        w_flip_x   = (w_hit_l && r_vel_x[W-1]) || (w_hit_r && !r_vel_x[W-1] && r_vel_x != '0);
        w_flip_y   = (w_hit_t && r_vel_y[W-1]) || (w_hit_b && !r_vel_y[W-1] && r_vel_y != '0);
`ifdef BORDER_DAMPING_EN
        w_refl_x   = damp(sat_neg(r_vel_x));
        w_refl_y   = damp(sat_neg(r_vel_y));
`else
        w_refl_x   = sat_neg(r_vel_x);
        w_refl_y   = sat_neg(r_vel_y);
`endif
        if (w_hit_next) begin
            w_vel_x_next = w_flip_x ? w_refl_x : r_vel_x;
            w_vel_y_next = w_flip_y ? w_refl_y : r_vel_y;
        end else begin
            w_vel_x_next = i_vel_x;
            w_vel_y_next = i_vel_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_vel_x     <= '0;
            r_vel_y     <= '0;
            r_vel_x_out <= '0;
            r_vel_y_out <= '0;
            r_collision <= 1'b0;
        end else begin
            if (r_state == ARMED && i_overlap) begin
                r_pos_x <= i_pos_x;
                r_pos_y <= i_pos_y;
                r_vel_x <= i_vel_x;
                r_vel_y <= i_vel_y;
            end
            // Loaded on the HIT edge, so a coincident frame pulse cannot shorten the cooldown.
            if (r_state == HIT)
                r_cnt <= CNT_W'(COOLDOWN_FRAMES);
            else if (r_state == COOLDOWN && i_start_of_frame && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            r_vel_x_out <= w_vel_x_next;
            r_vel_y_out <= w_vel_y_next;
            r_collision <= w_hit_next;
        end
    end

    assign o_vel_x     = r_vel_x_out;
    assign o_vel_y     = r_vel_y_out;
    assign o_collision = r_collision;
    assign o_hit_next  = w_hit_next;
    assign o_state     = r_state;

endmodule

// File: rtl/multi_border_collision.sv
// Table-border collision unit for NUM_BALLS independent balls; each ball has its own channel.
// Define BORDER_DAMPING_EN to scale every reflected velocity component by 7/8.
module multi_border_collision
    import border_collision_pkg::*;
#(
    parameter int NUM_BALLS       = 16,
    parameter int W               = DEF_W,
    parameter int BALL_SIZE       = DEF_BALL_SIZE,
    parameter int TOP_OFFSET      = 40,
    parameter int DOWN_OFFSET     = 440,
    parameter int LEFT_OFFSET     = 40,
    parameter int RIGHT_OFFSET    = 600,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [NUM_BALLS-1:0]   ballDR,
    input  logic                   bordersDR,
    input  logic [NUM_BALLS*W-1:0] ballTopLeftPosX,
    input  logic [NUM_BALLS*W-1:0] ballTopLeftPosY,
    input  logic [NUM_BALLS*W-1:0] ballVelX,
    input  logic [NUM_BALLS*W-1:0] ballVelY,
    output logic [NUM_BALLS*W-1:0] ballVelXOut,
    output logic [NUM_BALLS*W-1:0] ballVelYOut,
    output logic [NUM_BALLS-1:0]   collisionOccurred,
    output logic                   anyCollision,
    output logic [2*NUM_BALLS-1:0] dbgChannelState
);

    logic [NUM_BALLS-1:0] w_overlap;
    logic [NUM_BALLS-1:0] w_hit_next;
    logic                 r_any_collision;

    assign w_overlap = ballDR & {NUM_BALLS{bordersDR}};

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_chan
        border_collision_channel #(
            .W               (W),
            .BALL_SIZE       (BALL_SIZE),
            .TOP_OFFSET      (TOP_OFFSET),
            .DOWN_OFFSET     (DOWN_OFFSET),
            .LEFT_OFFSET     (LEFT_OFFSET),
            .RIGHT_OFFSET    (RIGHT_OFFSET),
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
        ) u_chan (
            .clk              (clk),
            .reset            (reset),
            .i_start_of_frame (startOfFrame),
            .i_overlap        (w_overlap[g]),
            .i_pos_x          (ballTopLeftPosX[g*W +: W]),
            .i_pos_y          (ballTopLeftPosY[g*W +: W]),
            .i_vel_x          (ballVelX[g*W +: W]),
            .i_vel_y          (ballVelY[g*W +: W]),
            .o_vel_x          (ballVelXOut[g*W +: W]),
            .o_vel_y          (ballVelYOut[g*W +: W]),
            .o_collision      (collisionOccurred[g]),
            .o_hit_next       (w_hit_next[g]),
            .o_state          (dbgChannelState[2*g +: 2])
        );
    end

    // Registered from the same term as the per-ball pulses so both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)
            r_any_collision <= 1'b0;
        else
            r_any_collision <= |w_hit_next;
    end

    assign anyCollision = r_any_collision;

endmodule

// File: doc/multi_border_collision.md
Name: multi_border_collision

Overview:
- Next-generation table-border collision unit: handles NUM_BALLS balls in parallel, one independent channel per ball.
- Per channel:
  - detects ball/border pixel overlap from drawing requests;
  - classifies the hit by position;
  - reflects only the velocity component that points into the wall;
  - holds off re-triggering for a frame-based cooldown.
- Sits between the ball objects and the hit controller's velocity mux; once per video pixel clock it takes in the ball drawing requests and the border drawing request.

Parameters:
- NUM_BALLS, 16, number of independent ball channels.
- W, 11, signed width of positions and velocities.
- BALL_SIZE, 32, ball bounding-box side in pixels.
- TOP_OFFSET, 40, Y of inner top border edge.
- DOWN_OFFSET, 440, Y of inner bottom border edge.
- LEFT_OFFSET, 40, X of inner left border edge.
- RIGHT_OFFSET, 600, X of inner right border edge.
- COOLDOWN_FRAMES, 2, frames a channel ignores overlap after a hit (0 = re-arm on overlap release only).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- ballDR  in  NUM_BALLS  per-ball drawing request.
- bordersDR  in  1  border drawing request.
- ballTopLeftPosX  in  NUM_BALLS x W signed  per-ball X.
- ballTopLeftPosY  in  NUM_BALLS x W signed  per-ball Y.
- ballVelX  in  NUM_BALLS x W signed  per-ball X velocity.
- ballVelY  in  NUM_BALLS x W signed  per-ball Y velocity.
- ballVelXOut  out  NUM_BALLS x W signed  registered corrected X velocity.
- ballVelYOut  out  NUM_BALLS x W signed  registered corrected Y velocity.
- collisionOccurred  out  NUM_BALLS  one-cycle hit pulse per ball.
- anyCollision  out  1  registered OR of this cycle's hit pulses.

Behaviour:
- Clock, reset and latency:
  - Single clock; reset is synchronous and active-high.
  - On reset: all channels go to ARMED with cooldown counter 0; all VelOut = 0; collisionOccurred = 0; anyCollision = 0.
  - All outputs are registered, latency 1 cycle.
  - Default each cycle: VelOut <= VelIn (pass-through); collisionOccurred[i] <= 0.
- Overlap: overlap[i] = ballDR[i] & bordersDR.
- Per-channel FSM:
  - ARMED: if overlap[i], go to HIT for exactly one cycle; else stay.
  - HIT: the cycle after detection, issue the pulse and velocity correction below, load cnt = COOLDOWN_FRAMES, go to COOLDOWN.
  - COOLDOWN: on startOfFrame with cnt > 0, decrement. When cnt == 0 and overlap[i] == 0, go to ARMED. Overlap held with cnt == 0 keeps the channel in COOLDOWN (no retrigger).
- Hit classification, using the inputs sampled in the detect cycle:
  - hitL = posX <= LEFT_OFFSET; hitR = posX + BALL_SIZE >= RIGHT_OFFSET.
  - hitT = posY <= TOP_OFFSET; hitB = posY + BALL_SIZE >= DOWN_OFFSET.
  - Comparisons are signed, carried out in W+1 bits to avoid overflow.
- Reflection:
  - flipX = (hitL & velX < 0) | (hitR & velX > 0). flipY is the analogous rule for Y.
  - Corner: both components are flipped in the same cycle.
  - A component of zero, or one already pointing away from the wall, is passed through unchanged.
- Negation: saturating; -(-2^(W-1)) = 2^(W-1) - 1.
- collisionOccurred[i] pulses in the HIT-output cycle even when no component flips (the hit is still counted for sound/score).
- Independence:
  - Channels are fully independent; simultaneous hits on several balls are all processed the same cycle.
  - startOfFrame coincident with entry to COOLDOWN does not decrement the freshly loaded count.
- Reset mid-cooldown or mid-HIT: channel returns to ARMED and the pending pulse is dropped.

Optional Feature:
- Macro: BORDER_DAMPING_EN.
- Defined: each flipped component is additionally scaled by 7/8, computed as n - (n >>> 3) on the negated value n. Arithmetic shift; the result is clamped so that a nonzero input never yields 0 (minimum magnitude 1, sign preserved).
- Undefined: pure sign reflection; no damping logic is present.

Decomposition:
- Package border_collision_pkg holds:
  - enum coll_state_t {ARMED, HIT, COOLDOWN};
  - default W and BALL_SIZE constants;
  - function sat_neg(W-bit signed);
  - function damp (compiled only under BORDER_DAMPING_EN).
- Sub-module border_collision_channel:
  - one ball's FSM, counter, classification and reflection;
  - instantiated NUM_BALLS times by a generate loop in the top.
- The top holds only the overlap vector and the anyCollision OR register.

Test Plan:
- Reset then idle: all VelOut = 0, no pulses. Release reset with velX[0] = 5: next cycle ballVelXOut[0] = 5.
- Left-wall hit, inward (ball 0): posX = 38, posY = 200, velX = -7, velY = 3, overlap held 20 cycles -> exactly one pulse; VelOut = (7, 3); no second pulse until cooldown expires and overlap drops.
- Outward-moving overlap: posX = 38, velX = +7 -> pulse = 1, VelOut = (7, v) unchanged (no flip back into the wall).
- Corner + saturation: posX = 600 - 32, posY = 440 - 32, velX = +4, velY = -1024 (W = 11) -> VelOut = (-4, -1024). Then the Y variant with posY = 40, velY = -1024 -> +1023.
- Cooldown: COOLDOWN_FRAMES = 2, overlap released right after the hit, re-asserted before 2 startOfFrame pulses -> ignored. Re-asserted after the 2nd startOfFrame with overlap released in between -> new pulse.
- Multi-ball plus reset: balls 0 and 3 overlap in the same cycle -> both pulse, anyCollision = 1. Reset asserted in the HIT cycle -> no pulse, both channels ARMED. Under BORDER_DAMPING_EN: velX = -16 on the left wall -> 14; velX = -1 -> 1.
